// File: rtl/io_uart_ctrl.sv
// io_uart_ctrl: bridges io_core byte-sized requests to a UART byte stream.
// Ports: io_* request/accept/done handshake and data; uart_rx_* in
//   (buffered in an RX_DEPTH byte FIFO), uart_tx_* out (valid/ready);
//   rx_overflow is a sticky flag for a dropped received byte.
module io_uart_ctrl #(
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_order,
  output logic        io_accepted,
  output logic        io_done,
  input  logic        io_write_flag,
  input  logic [1:0]  io_size,
  input  logic [31:0] io_o_data,
  output logic [31:0] io_i_data,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  output logic        rx_overflow
);

  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TX,
    S_RX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [1:0]    r_last;
  logic [1:0]    r_idx;
  logic [7:0]    r_mem [RX_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic       w_tx_fire;
  logic [7:0] w_pop_byte;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = (r_state == S_RX) && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push     = uart_rx_valid && !rst && (!w_full || w_pop);
  assign w_drop     = uart_rx_valid && w_full && !w_pop;
  assign w_tx_fire  = uart_tx_valid && uart_tx_ready;
  assign w_pop_byte = r_mem[r_rptr];

  assign io_i_data    = r_rdata;
  assign rx_overflow  = r_ovf;
  // r_wdata shifts right per sent byte, so the current byte is always [7:0].
  assign uart_tx_data = uart_tx_valid ? r_wdata[7:0] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    io_accepted   = 1'b0;
    io_done       = 1'b0;
    uart_tx_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io_order && !rst) begin
          io_accepted = 1'b1;
          w_next      = io_write_flag ? S_TX : S_RX;
        end
      end
      S_TX: begin
        uart_tx_valid = 1'b1;
        if (uart_tx_ready && (r_idx == r_last)) w_next = S_DONE;
      end
      S_RX: begin
        if (!w_empty && (r_idx == r_last)) w_next = S_DONE;
      end
      S_DONE: begin
        io_done = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdata <= '0;
      r_rdata <= '0;
      r_last  <= '0;
      r_idx   <= '0;
    end else if (io_accepted) begin
      r_wdata <= io_o_data;
      r_idx   <= '0;
      unique case (io_size)
        2'd0:    r_last <= 2'd0;
        2'd1:    r_last <= 2'd1;
        default: r_last <= 2'd3;
      endcase
      if (!io_write_flag) r_rdata <= '0;
    end else if (w_tx_fire) begin
      r_wdata <= r_wdata >> 8;
      r_idx   <= r_idx + 2'd1;
    end else if (w_pop) begin
      r_rdata[{r_idx, 3'b000} +: 8] <= w_pop_byte;
      r_idx <= r_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= uart_rx_data;
  end

endmodule
